// File: rtl/load_store_unit.sv
// Memory stage: one load or store per request on a req/ack bus.
// Returns extended load data or flags misalign/bus timeout.
module load_store_unit #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_misalign,
   output logic        rsp_buserr
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUS,
      S_RESP
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_cnt;
   logic        r_is_store;
   logic [2:0]  r_funct3;
   logic [1:0]  r_alo;

   logic        w_accept;
   logic        w_legal;
   logic        w_aligned;
   logic        w_bad;
   logic        w_timeout;
   logic [3:0]  w_strb;
   logic [31:0] w_lane_data;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_ldata;

   assign req_ready = (r_state == S_IDLE);
   assign w_accept  = req_valid & req_ready;
   assign w_bad     = ~(w_legal & w_aligned);
   assign w_timeout = (r_cnt == LIMIT);

   // Legality and natural alignment of the incoming request
   always_comb begin
      w_legal   = 1'b0;
      w_aligned = 1'b0;
      case (req_funct3)
         3'b000, 3'b001, 3'b010: w_legal = 1'b1;
         3'b100, 3'b101:         w_legal = ~req_is_store;
         default:                w_legal = 1'b0;
      endcase
      case (req_funct3[1:0])
         2'b00:   w_aligned = 1'b1;
         2'b01:   w_aligned = ~req_addr[0];
         2'b10:   w_aligned = (req_addr[1:0] == 2'b00);
         default: w_aligned = 1'b0;
      endcase
   end

   // Store byte enables and lane-replicated store data
   always_comb begin
      w_strb      = 4'b1111;
      w_lane_data = req_wdata;
      case (req_funct3[1:0])
         2'b00: begin
            w_strb      = 4'b0001 << req_addr[1:0];
            w_lane_data = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            w_strb      = req_addr[1] ? 4'b1100 : 4'b0011;
            w_lane_data = {2{req_wdata[15:0]}};
         end
         default: begin
            w_strb      = 4'b1111;
            w_lane_data = req_wdata;
         end
      endcase
   end

   // Load byte/half extraction and sign or zero extension
   always_comb begin
      w_byte  = mem_rdata[7:0];
      case (r_alo)
         2'b00:   w_byte = mem_rdata[7:0];
         2'b01:   w_byte = mem_rdata[15:8];
         2'b10:   w_byte = mem_rdata[23:16];
         default: w_byte = mem_rdata[31:24];
      endcase
      w_half  = r_alo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      w_ldata = mem_rdata;
      case (r_funct3)
         3'b000:  w_ldata = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_ldata = {{16{w_half[15]}}, w_half};
         3'b100:  w_ldata = {24'b0, w_byte};
         3'b101:  w_ldata = {16'b0, w_half};
         default: w_ldata = mem_rdata;
      endcase
   end

   // Next-state selection
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_next = w_bad ? S_RESP : S_BUS;
            end
         end
         S_BUS: begin
            if (mem_ack || w_timeout) begin
               w_next = S_RESP;
            end
         end
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Registered bus/response outputs, captured request and timeout counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt        <= 8'd0;
         r_is_store   <= 1'b0;
         r_funct3     <= 3'b000;
         r_alo        <= 2'b00;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= 32'd0;
         mem_wdata    <= 32'd0;
         mem_wstrb    <= 4'd0;
         rsp_valid    <= 1'b0;
         rsp_rdata    <= 32'd0;
         rsp_misalign <= 1'b0;
         rsp_buserr   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_is_store <= req_is_store;
                  r_funct3   <= req_funct3;
                  r_alo      <= req_addr[1:0];
                  r_cnt      <= 8'd0;
                  if (w_bad) begin
                     rsp_valid    <= 1'b1;
                     rsp_misalign <= 1'b1;
                     rsp_rdata    <= 32'd0;
                  end else begin
                     mem_req   <= 1'b1;
                     mem_we    <= req_is_store;
                     mem_addr  <= {req_addr[31:2], 2'b00};
                     mem_wdata <= req_is_store ? w_lane_data : 32'd0;
                     mem_wstrb <= req_is_store ? w_strb : 4'd0;
                  end
               end
            end
            S_BUS: begin
               if (mem_ack || w_timeout) begin
                  mem_req    <= 1'b0;
                  mem_we     <= 1'b0;
                  mem_addr   <= 32'd0;
                  mem_wdata  <= 32'd0;
                  mem_wstrb  <= 4'd0;
                  rsp_valid  <= 1'b1;
                  rsp_buserr <= ~mem_ack;
                  if (mem_ack && !r_is_store) begin
                     rsp_rdata <= w_ldata;
                  end else begin
                     rsp_rdata <= 32'd0;
                  end
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_RESP: begin
               rsp_misalign <= 1'b0;
               rsp_buserr   <= 1'b0;
            end
            default: begin
               rsp_misalign <= 1'b0;
               rsp_buserr   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a behavioural model,
// plus directed literal checks of the key scenarios.
module tb_load_store_unit;

   localparam int T = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_is_store = 1'b0;
   logic [2:0]  req_funct3 = 3'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'd0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_misalign;
   logic        rsp_buserr;

   load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_is_store(req_is_store), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_misalign(rsp_misalign), .rsp_buserr(rsp_buserr)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------- spec-level helper functions ----------
   function automatic bit acc_ok(bit st, logic [2:0] f, logic [1:0] a);
      int sz;
      bit lg;
      if (st) lg = (f <= 3'd2);
      else    lg = (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      if (f[1:0] == 2'd3) return 1'b0;
      sz = 1 << f[1:0];
      return lg && ((int'(a) % sz) == 0);
   endfunction

   function automatic logic [3:0] strb_of(logic [2:0] f, logic [1:0] a);
      int sz;
      sz = 1 << f[1:0];
      return 4'(((1 << sz) - 1) << a);
   endfunction

   function automatic logic [31:0] wd_of(logic [2:0] f, logic [31:0] wd);
      int sz;
      logic [31:0] r;
      sz = 1 << f[1:0];
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] ld_of(logic [2:0] f, logic [1:0] a,
                                         logic [31:0] rd);
      logic [31:0] b;
      logic [31:0] h;
      b = rd >> (8 * a);
      h = rd >> (16 * a[1]);
      case (f)
         3'd0:    return 32'($signed(b[7:0]));
         3'd1:    return 32'($signed(h[15:0]));
         3'd2:    return rd;
         3'd4:    return {24'd0, b[7:0]};
         3'd5:    return {16'd0, h[15:0]};
         default: return 32'd0;
      endcase
   endfunction

   // ---------- behavioural model ----------
   bit          m_ready = 1'b1, m_memreq = 1'b0, m_rv = 1'b0;
   bit          m_mis = 1'b0, m_be = 1'b0, m_we = 1'b0, m_st = 1'b0;
   logic [31:0] m_addr = 0, m_wd = 0, m_rd = 0;
   logic [3:0]  m_strb = 0;
   logic [2:0]  m_f = 0;
   logic [1:0]  m_a = 0;
   int          m_wait = 0;
   int          m_phase = 0;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_ready = 1; m_memreq = 0; m_rv = 0; m_mis = 0; m_be = 0;
         m_rd = 0; m_phase = 0; m_wait = 0;
      end else if (m_phase == 0) begin
         if (req_valid) begin
            m_st = req_is_store; m_f = req_funct3; m_a = req_addr[1:0];
            m_ready = 0;
            if (!acc_ok(m_st, m_f, m_a)) begin
               m_rv = 1; m_mis = 1; m_rd = 0; m_phase = 2;
            end else begin
               m_memreq = 1; m_we = m_st;
               m_addr = req_addr & 32'hFFFF_FFFC;
               m_wd = m_st ? wd_of(m_f, req_wdata) : 32'd0;
               m_strb = m_st ? strb_of(m_f, m_a) : 4'd0;
               m_wait = 1; m_phase = 1;
            end
         end
      end else if (m_phase == 1) begin
         if (mem_ack) begin
            m_memreq = 0; m_rv = 1; m_phase = 2;
            m_rd = m_st ? 32'd0 : ld_of(m_f, m_a, mem_rdata);
         end else if (m_wait == T) begin
            m_memreq = 0; m_rv = 1; m_be = 1; m_rd = 0; m_phase = 2;
         end else begin
            m_wait++;
         end
      end else begin
         m_rv = 0; m_mis = 0; m_be = 0; m_ready = 1; m_phase = 0;
      end
   end

   // ---------- per-cycle compare ----------
   initial forever begin
      @(negedge clk);
      chk("req_ready", req_ready, m_ready);
      chk("mem_req", mem_req, m_memreq);
      chk("rsp_valid", rsp_valid, m_rv);
      chk("rsp_misalign", rsp_misalign, m_mis);
      chk("rsp_buserr", rsp_buserr, m_be);
      chk("rsp_rdata", rsp_rdata, m_rd);
      if (m_memreq) begin
         chk("mem_we", mem_we, m_we);
         chk("mem_addr", mem_addr, m_addr);
         chk("mem_wdata", mem_wdata, m_wd);
         chk("mem_wstrb", mem_wstrb, m_strb);
      end
   end

   // ---------- bus responder ----------
   int          g_ackd = 0;
   logic [31:0] g_rdata = 0;
   bit          g_stray = 0;
   int          rcnt = 0;

   initial forever begin
      @(negedge clk);
      #1;
      if (g_stray) begin
         mem_ack = 1; mem_rdata = $urandom;
      end else if (mem_req) begin
         if (rcnt == g_ackd) begin
            mem_ack = 1; mem_rdata = g_rdata;
         end else begin
            mem_ack = 0; mem_rdata = $urandom;
         end
         rcnt++;
      end else begin
         mem_ack = 0; rcnt = 0; mem_rdata = $urandom;
      end
   end

   // ---------- transaction driver (call at a negedge) ----------
   logic [31:0] o_rd, o_addr, o_wd;
   logic [3:0]  o_strb;
   bit          o_mis, o_be, o_we, o_rdy;
   int          o_cyc, o_lat;

   task automatic do_txn(input bit st, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int ackd, input logic [31:0] rd);
      int n;
      bit seen;
      g_ackd = ackd; g_rdata = rd;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk); n++;
      end
      chk("ready_wait", req_ready, 1);
      req_valid = 1; req_is_store = st; req_funct3 = f;
      req_addr = a; req_wdata = wd;
      @(negedge clk);
      req_valid = 0; req_is_store = 1'($urandom);
      req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
      o_cyc = 0; o_rd = 0; o_mis = 0; o_be = 0; o_we = 0;
      o_addr = 0; o_wd = 0; o_strb = 0; o_lat = 0; seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (mem_req) begin
            o_cyc++; o_addr = mem_addr; o_wd = mem_wdata;
            o_strb = mem_wstrb; o_we = mem_we;
         end
         if (rsp_valid) begin
            o_rd = rsp_rdata; o_mis = rsp_misalign; o_be = rsp_buserr;
            o_lat = i + 1; seen = 1;
            break;
         end
         @(negedge clk);
      end
      chk("rsp_seen", seen, 1);
      @(negedge clk);
      o_rdy = req_ready;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_ready", req_ready, 1);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      rst_n = 1;
      @(negedge clk);

      do_txn(0, 3'd2, 32'h100, 0, 2, 32'hDEADBEEF);
      chk("lw_addr", o_addr, 32'h100);
      chk("lw_strb", o_strb, 4'h0);
      chk("lw_rdata", o_rd, 32'hDEADBEEF);
      chk("lw_reqcyc", o_cyc, 3);
      chk("lw_lat", o_lat, 4);

      do_txn(0, 3'd0, 32'h103, 0, 0, 32'h80FFFF7F);
      chk("lb_rdata", o_rd, 32'hFFFFFF80);
      do_txn(0, 3'd4, 32'h103, 0, 1, 32'h80FFFF7F);
      chk("lbu_rdata", o_rd, 32'h00000080);

      do_txn(1, 3'd1, 32'h202, 32'h1234ABCD, 0, 32'h0);
      chk("sh_we", o_we, 1);
      chk("sh_strb", o_strb, 4'hC);
      chk("sh_wdata", o_wd, 32'hABCDABCD);
      chk("sh_rdata", o_rd, 0);

      do_txn(0, 3'd2, 32'h101, 0, 0, 32'h0);
      chk("mis_reqcyc", o_cyc, 0);
      chk("mis_flag", o_mis, 1);
      chk("mis_lat", o_lat, 1);
      chk("mis_ready", o_rdy, 1);

      do_txn(0, 3'd2, 32'h400, 0, 99, 32'h0);
      chk("to_reqcyc", o_cyc, T);
      chk("to_buserr", o_be, 1);
      chk("to_rdata", o_rd, 0);
      do_txn(0, 3'd2, 32'h404, 0, T - 1, 32'h55AA55AA);
      chk("late_reqcyc", o_cyc, T);
      chk("late_buserr", o_be, 0);
      chk("late_rdata", o_rd, 32'h55AA55AA);

      g_ackd = 99;
      while (!req_ready) @(negedge clk);
      req_valid = 1; req_is_store = 0; req_funct3 = 3'd2;
      req_addr = 32'h40;
      @(negedge clk);
      req_valid = 0;
      chk("rst_bus_req", mem_req, 1);
      #2 rst_n = 0;
      #1 chk("rst_async_drop", mem_req, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
      g_stray = 1;
      @(negedge clk);
      g_stray = 0;
      for (int i = 0; i < 3; i++) begin
         chk("stray_no_rsp", rsp_valid, 0);
         @(negedge clk);
      end
      do_txn(0, 3'd2, 32'h80, 0, 1, 32'hCAFEF00D);
      chk("post_rst_lw", o_rd, 32'hCAFEF00D);

      for (int k = 0; k < 400; k++) begin
         do_txn(1'($urandom), 3'($urandom), $urandom, $urandom,
                int'($urandom_range(0, 5)), $urandom);
         if ($urandom_range(0, 3) == 0) begin
            g_stray = 1'($urandom);
            @(negedge clk);
            g_stray = 0;
         end
      end

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
